// File: rtl/catanddog_pkg.sv
// Shared keypad types: FSM states, row drive patterns and column decode helpers.
// Pure declarations; no latency and no flow control of its own.
// Imported by every keypad block so that encodings cannot drift between files.
package catanddog_pkg;

  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    PRESS_DEB = 2'd1,
    PRESSED   = 2'd2,
    REL_DEB   = 2'd3
  } state_e;

  localparam logic [3:0] ROW_DRV0 = 4'b1110;
  localparam logic [3:0] ROW_DRV1 = 4'b1101;
  localparam logic [3:0] ROW_DRV2 = 4'b1011;
  localparam logic [3:0] ROW_DRV3 = 4'b0111;

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    case (idx)
      2'd0:    row_drive = ROW_DRV0;
      2'd1:    row_drive = ROW_DRV1;
      2'd2:    row_drive = ROW_DRV2;
      default: row_drive = ROW_DRV3;
    endcase
  endfunction

  // Only a lone closed column is trusted; anything else may be ghosting.
  function automatic logic single_zero(input logic [3:0] col);
    case (col)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single_zero = 1'b1;
      default:                            single_zero = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] zero_index(input logic [3:0] col);
    case (col)
      4'b1101: zero_index = 2'd1;
      4'b1011: zero_index = 2'd2;
      4'b0111: zero_index = 2'd3;
      default: zero_index = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/kb_sync.sv
// Two-flop synchronizer for the asynchronous keypad column lines.
// Latency 2 cycles; no backpressure, samples every cycle.
// Resets to all-ones so an idle (pulled-up) keypad is seen straight out of reset.
module kb_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with press/release debounce and a single-entry key register.
// Latency: key-to-valid at most 2 + 4*DWELL + DEBOUNCE_MS + 1 cycles.
// Backpressure: key_valid/key_ack handshake; a press arriving while unacknowledged is dropped and flagged.
module keypad_scan
  import catanddog_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int DWELL       = 4
) (
  input  logic             clk_1kHz,
  input  logic             rst_n,
  input  logic [3:0]       kb_col,
  output logic [3:0]       kb_row,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ack,
  output logic             key_held,
  output logic             err_overrun
);

  localparam int                DEB_W      = $clog2(DEBOUNCE_MS + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEBOUNCE_MS - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX    = DEB_W'(DEBOUNCE_MS);
  localparam logic [3:0]        DWELL_LAST = 4'(DWELL - 1);

  if (DWELL < 3 || DWELL > 15) begin : g_bad_dwell
    $error("keypad_scan: DWELL must be within 3..15");
  end

  logic [3:0]       col_s;
  state_e           state;
  logic [1:0]       row_idx;
  logic [1:0]       col_idx;
  logic [3:0]       col_lat;
  logic [3:0]       dwell_cnt;
  logic [DEB_W-1:0] deb_cnt;
  logic [DEB_W-1:0] deb_inc;
  logic             key_evt;

  kb_sync u_sync (
    .clk   (clk_1kHz),
    .rst_n (rst_n),
    .d     (kb_col),
    .q     (col_s)
  );

  assign deb_inc = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + 1'b1;

  // The press is accepted on the last matching debounce cycle.
  assign key_evt = (state == PRESS_DEB) && (col_s == col_lat) && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk_1kHz) begin
    if (!rst_n) begin
      state       <= SCAN;
      row_idx     <= 2'd0;
      col_idx     <= 2'd0;
      col_lat     <= 4'hF;
      dwell_cnt   <= 4'd0;
      deb_cnt     <= '0;
      kb_row      <= ROW_DRV0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (dwell_cnt == DWELL_LAST) begin
            if (single_zero(col_s)) begin
              col_lat <= col_s;
              col_idx <= zero_index(col_s);
              deb_cnt <= '0;
              state   <= PRESS_DEB;
            end else begin
              row_idx   <= row_idx + 2'd1;
              kb_row    <= row_drive(row_idx + 2'd1);
              dwell_cnt <= 4'd0;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 4'd1;
          end
        end

        PRESS_DEB: begin
          if (col_s != col_lat) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            dwell_cnt <= 4'd0;
            kb_row    <= ROW_DRV0;
          end else if (deb_cnt == DEB_LAST) begin
            state    <= PRESSED;
            key_held <= 1'b1;
          end else begin
            deb_cnt <= deb_inc;
          end
        end

        PRESSED: begin
          if (col_s == 4'hF) begin
            state   <= REL_DEB;
            deb_cnt <= '0;
          end
        end

        REL_DEB: begin
          if (col_s != 4'hF) begin
            state <= PRESSED;
          end else if (deb_cnt == DEB_LAST) begin
            state     <= SCAN;
            key_held  <= 1'b0;
            row_idx   <= 2'd0;
            dwell_cnt <= 4'd0;
            kb_row    <= ROW_DRV0;
          end else begin
            deb_cnt <= deb_inc;
          end
        end

        default: begin
          state     <= SCAN;
          key_held  <= 1'b0;
          row_idx   <= 2'd0;
          dwell_cnt <= 4'd0;
          kb_row    <= ROW_DRV0;
        end
      endcase

      if (key_evt) begin
        if (!key_valid || key_ack) begin
          key_code  <= {row_idx, col_idx};
          key_valid <= 1'b1;
        end else begin
          err_overrun <= 1'b1;
        end
      end else if (key_valid && key_ack) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The parameter DEBOUNCE_MS SHALL have default 20 and set the stable cycles (1 ms each) required for press and for release.
REQ-002 The parameter DWELL SHALL have default 4 and set the clock cycles each row is driven before its columns are sampled; legal range 3..15.
REQ-003 clk_1kHz  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 kb_col  input  4  keypad column lines, pulled up, low = key closed; asynchronous.
REQ-006 kb_row  output  4  keypad row drive, exactly one bit low at any time.
REQ-007 key_code  output  4  decoded key, row_index*4 + col_index.
REQ-008 key_valid  output  1  key_code holds an unacknowledged key.
REQ-009 key_ack  input  1  consumer accepts key_code; effective only while key_valid=1.
REQ-010 key_held  output  1  a debounced key is currently down.
REQ-011 err_overrun  output  1  sticky; a debounced press was dropped because key_valid was still 1.

Function
REQ-012 kb_col SHALL pass through a two-flop synchronizer; all column decisions SHALL use the synchronized value col_s.
REQ-013 The FSM SHALL have states SCAN, PRESS_DEB, PRESSED, REL_DEB.
REQ-014 In SCAN, kb_row SHALL cycle 1110 -> 1101 -> 1011 -> 0111 -> 1110, each pattern held DWELL cycles.
REQ-015 In SCAN, col_s SHALL be evaluated only on the last dwell cycle of each row.
REQ-016 If col_s then has exactly one zero bit, the FSM SHALL latch row and column index, freeze kb_row, clear the debounce counter and enter PRESS_DEB; otherwise the scan continues.
REQ-017 Patterns with zero or with two or more zero bits (ghosting or multi-key) SHALL be ignored in SCAN.
REQ-018 In PRESS_DEB, any cycle with col_s different from the latched pattern SHALL return the FSM to SCAN at row 0.
REQ-019 In PRESS_DEB, DEBOUNCE_MS consecutive matching cycles SHALL enter PRESSED and produce a key event on that transition cycle.
REQ-020 On a key event with key_valid=0, key_code SHALL load and key_valid SHALL rise on the next edge.
REQ-021 On a key event with key_valid=1 and key_ack=1 in the same cycle, the new code SHALL load and key_valid SHALL stay 1.
REQ-022 On a key event with key_valid=1 and key_ack=0, the event SHALL be dropped, err_overrun SHALL set, and key_code SHALL be unchanged.
REQ-023 key_ack with key_valid=1 and no key event SHALL clear key_valid on the next edge.
REQ-024 key_ack with key_valid=0 SHALL have no effect.
REQ-025 key_held SHALL be 1 exactly while the FSM is in PRESSED or REL_DEB.
REQ-026 In PRESSED, kb_row SHALL stay frozen; col_s=1111 SHALL enter REL_DEB with the counter cleared.
REQ-027 In REL_DEB, any col_s not equal to 1111 SHALL return to PRESSED without a new key event.
REQ-028 In REL_DEB, DEBOUNCE_MS consecutive cycles of 1111 SHALL return to SCAN at row 0.
REQ-029 The debounce counter SHALL be ceil(log2(DEBOUNCE_MS+1)) bits wide and SHALL saturate, never wrap.
REQ-030 Key-to-valid latency SHALL be at most 2 (sync) + 4*DWELL (scan) + DEBOUNCE_MS + 1 cycles.

Reset
REQ-031 With rst_n=0 at an edge: state=SCAN, row index 0, kb_row=1110, key_code=0, key_valid=0, key_held=0, err_overrun=0, counters 0, synchronizer flops=1111.
REQ-032 Reset asserted mid-debounce or mid-handshake SHALL discard the pending key with no key_valid pulse.
REQ-033 err_overrun SHALL clear only by reset.

Structure
REQ-034 The state enum, the row drive constants (1110, 1101, 1011, 0111) and the KEY_W=4 width constant SHALL live in shared package catanddog_pkg.
REQ-035 The two-flop synchronizer SHALL be sub-module kb_sync (4 bits, reset to 1111); all other logic SHALL be in keypad_scan.

Verification (DEBOUNCE_MS=20, DWELL=4)
REQ-036 Hold key row 2 / col 1 (kb_col=1101 while kb_row=1011) for 100 cycles -> key_code=9, key_valid=1 within 39 cycles, key_held=1, kb_row frozen at 1011.
REQ-037 Same key bouncing every 5 cycles for 40 cycles, then stable -> exactly one key_valid rise, 20 stable cycles after the last bounce.
REQ-038 Press key 0, no ack, release, then press key 15 -> key_code stays 0, err_overrun=1; ack then press key 5 -> key_code=5.
REQ-039 key_ack asserted on the same cycle as key 3's event, while key 7 is pending -> key_code=3, key_valid stays 1.
REQ-040 Release for 10 cycles then re-close -> no second event; release for 20 cycles -> SCAN resumes with kb_row=1110.
REQ-041 Two keys in one row (kb_col=1001) -> no event; rst_n=0 mid PRESS_DEB -> all outputs at reset values, no event.
